tcp_tx_segmenter: RTL and testbench
===================================

Name: tcp_tx_segmenter

Overview:
- Sits between the TCP benchmark engines and the TCP stack TX path.
- Accepts one send request of arbitrary byte length, plus its 512-bit data stream.
- Splits the request into segments of at most MAX_SEG_BYTES, each with its own tx metadata.
- Waits for stack tx status per segment, retries on "no space", drops on fatal error. Frees engines from MSS/buffer-space handling.

Parameters:
MAX_SEG_BYTES, 1024, max bytes per segment; multiple of 64, >=64
MAX_RETRY, 8, retries per segment before drop
RETRY_WAIT, 64, backoff cycles between retries

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
s_axis_tx_req (axis_meta.slave)  in  48  request {len[31:0],session[15:0]}; len>0
s_axis_tx_data (axi_stream.slave)  in  512/64/1  request payload, data/keep/last
m_axis_tx_metadata (axis_meta.master)  out  48  per-segment {16'b0,seg_len[15:0],session[15:0]}
m_axis_tx_data (axi_stream.master)  out  512/64/1  segment payload
s_axis_tx_status (axis_meta.slave)  in  64  [15:0] session, [31:16] len, [61:32] space, [63:62] err (0 ok, 1 retry, 2 fatal)
status_reg  output  4x32  [0] segments sent, [1] retries, [2] drops, [3] {31'b0,busy}

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, all valid 0, s_axis_tx_req.ready 0, s_axis_tx_status.ready 0.
- FSM states:
  - IDLE: s_axis_tx_req.ready=1. Handshake latches session and remaining=len, clears retry_cnt, goes to SEG_CMD. busy=0 only in IDLE.
  - SEG_CMD: seg_len=min(remaining,MAX_SEG_BYTES), registered on entry. m_axis_tx_metadata.valid=1, data stable until ready. Handshake goes to WAIT_STATUS.
  - WAIT_STATUS: s_axis_tx_status.ready=1. Status is consumed regardless of its session field.
    - err=0: go to SEG_DATA, clear retry_cnt.
    - err=1 and retry_cnt<MAX_RETRY: retry_cnt++, retries counter++, go to BACKOFF.
    - err=2, or err=1 with retry_cnt==MAX_RETRY: go to DROP, drops++.
    - err=3: treated as fatal.
  - BACKOFF: counts RETRY_WAIT cycles, then returns to SEG_CMD with the same seg_len.
  - SEG_DATA: pure combinational passthrough, zero latency.
    - m.valid = s.valid; s.ready = m.ready; data forwarded unchanged.
    - beat_cnt counts handshakes. m.last on beat ceil(seg_len/64)-1.
    - keep = all-ones, except the last beat of the final segment: low (remaining mod 64) bytes set when non-zero.
    - After the last beat: segments++, remaining -= seg_len. remaining==0 goes to IDLE, else SEG_CMD.
  - DROP: s_axis_tx_data.ready=1, m.valid=0. Discards beats through upstream last, then IDLE.
- Upstream last is ignored outside DROP. If upstream last arrives before the final segment ends, transmission continues with the next upstream beats; upstream framing must match len.
- Arithmetic:
  - remaining is 32-bit unsigned; seg_len is at most 16 bits.
  - Beat count = (seg_len+63)>>6.
  - Counters wrap at 2^32.
- No request is accepted while busy. Back-to-back requests: IDLE lasts at least one cycle between requests.
- Reset mid-operation aborts immediately. Beats still pending upstream are the source's responsibility.

Optional Feature:
- Macro: TX_SEGMENTER_LATENCY_EN.
- When defined:
  - A 32-bit counter starts at request accept and stops at the final segment's last beat.
  - The value is exposed as extra output latency_cycles[31:0], held until the next request.
  - Drop leaves the counter frozen at the drop time.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Request len=2560, session=5; stack status always ok -> metadata lens 1024/1024/512, data bursts 16/16/8 beats with last on each burst end; status_reg[0]=3, busy back to 0.
- Request len=100 -> one metadata len 100; 2 beats, second keep=64'h0000_000F_FFFF_FFFF; last on beat 2.
- len=1024, status err=1 twice then ok -> exactly 3 metadata issues, at least 64 idle cycles between each; status_reg[1]=2; data sent once.
- len=2048, first segment ok, second gets err=2 -> 16 beats forwarded, remaining 16 upstream beats consumed with m.valid=0; status_reg[2]=1; IDLE after upstream last.
- err=1 nine times with MAX_RETRY=8 -> 8 retries then drop; status_reg[1]=8, status_reg[2]=1.
- rst asserted mid-SEG_DATA of a 2048-byte request -> all valids 0 and counters 0 immediately; new request len=64 then completes normally.

Source files
------------

// File: rtl/tcp_tx_segmenter.sv
// TCP TX segmenter: splits one send request into segments of at most MAX_SEG_BYTES, retrying or dropping on stack status.
// Optional build macro TX_SEGMENTER_LATENCY_EN adds latency_cycles_o (request accept to final segment's last beat).
module tcp_tx_segmenter #(
  parameter int unsigned MAX_SEG_BYTES = 1024,
  parameter int unsigned MAX_RETRY     = 8,
  parameter int unsigned RETRY_WAIT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_axis_tx_req_valid_i,
  output logic         s_axis_tx_req_ready_o,
  input  logic [47:0]  s_axis_tx_req_data_i,
  input  logic         s_axis_tx_data_valid_i,
  output logic         s_axis_tx_data_ready_o,
  input  logic [511:0] s_axis_tx_data_data_i,
  input  logic [63:0]  s_axis_tx_data_keep_i,
  input  logic         s_axis_tx_data_last_i,
  output logic         m_axis_tx_metadata_valid_o,
  input  logic         m_axis_tx_metadata_ready_i,
  output logic [47:0]  m_axis_tx_metadata_data_o,
  output logic         m_axis_tx_data_valid_o,
  input  logic         m_axis_tx_data_ready_i,
  output logic [511:0] m_axis_tx_data_data_o,
  output logic [63:0]  m_axis_tx_data_keep_o,
  output logic         m_axis_tx_data_last_o,
  input  logic         s_axis_tx_status_valid_i,
  output logic         s_axis_tx_status_ready_o,
  input  logic [63:0]  s_axis_tx_status_data_i,
  output logic [127:0] status_reg_o
`ifdef TX_SEGMENTER_LATENCY_EN
  ,
  output logic [31:0]  latency_cycles_o
`endif
);

  typedef enum logic [2:0] {IDLE, SEG_CMD, WAIT_STATUS, BACKOFF, SEG_DATA, DROP} state_e;

  state_e      state_q;
  logic        req_ready_q, meta_valid_q, stat_ready_q;
  logic [15:0] session_q, seg_len_q;
  logic [31:0] remaining_q, retry_cnt_q, backoff_q;
  logic [31:0] seg_cnt_q, retries_q, drops_q;
  logic [10:0] beat_cnt_q;

  logic [16:0] beats;
  logic        last_beat, final_seg, down_hs, stat_hs, fatal;
  logic [1:0]  err;
  logic [31:0] rem_after;
  logic        unused_bits;

  function automatic logic [15:0] seg_of(input logic [31:0] r);
    return (r > 32'(MAX_SEG_BYTES)) ? 16'(MAX_SEG_BYTES) : r[15:0];
  endfunction

  assign beats     = (17'(seg_len_q) + 17'd63) >> 6;
  assign last_beat = ({6'd0, beat_cnt_q} == beats - 17'd1);
  assign final_seg = (remaining_q == {16'd0, seg_len_q});
  assign rem_after = remaining_q - {16'd0, seg_len_q};
  assign err       = s_axis_tx_status_data_i[63:62];
  assign down_hs   = (state_q == SEG_DATA) && s_axis_tx_data_valid_i && m_axis_tx_data_ready_i;
  assign stat_hs   = (state_q == WAIT_STATUS) && stat_ready_q && s_axis_tx_status_valid_i;
  // err=3 is treated like err=2; err=1 becomes fatal once the retry budget is spent
  assign fatal     = err[1] || ((err == 2'd1) && !(retry_cnt_q < 32'(MAX_RETRY)));

  // Zero-latency data passthrough while a segment is being sent; sink-only while dropping
  assign m_axis_tx_data_valid_o = (state_q == SEG_DATA) && s_axis_tx_data_valid_i;
  assign s_axis_tx_data_ready_o = ((state_q == SEG_DATA) && m_axis_tx_data_ready_i) || (state_q == DROP);
  assign m_axis_tx_data_data_o  = s_axis_tx_data_data_i;
  assign m_axis_tx_data_last_o  = (state_q == SEG_DATA) && last_beat;
  assign m_axis_tx_data_keep_o  = (final_seg && last_beat && (seg_len_q[5:0] != 6'd0))
                                  ? ((64'd1 << seg_len_q[5:0]) - 64'd1) : {64{1'b1}};

  assign s_axis_tx_req_ready_o      = req_ready_q;
  assign s_axis_tx_status_ready_o   = stat_ready_q;
  assign m_axis_tx_metadata_valid_o = meta_valid_q;
  assign m_axis_tx_metadata_data_o  = {16'd0, seg_len_q, session_q};
  assign status_reg_o = {31'd0, (state_q != IDLE), drops_q, retries_q, seg_cnt_q};

  assign unused_bits = ^{s_axis_tx_data_keep_i, s_axis_tx_status_data_i[61:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      meta_valid_q <= 1'b0;
      stat_ready_q <= 1'b0;
      session_q    <= '0;
      seg_len_q    <= '0;
      remaining_q  <= '0;
      retry_cnt_q  <= '0;
      backoff_q    <= '0;
      seg_cnt_q    <= '0;
      retries_q    <= '0;
      drops_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && s_axis_tx_req_valid_i) begin
            req_ready_q  <= 1'b0;
            session_q    <= s_axis_tx_req_data_i[15:0];
            remaining_q  <= s_axis_tx_req_data_i[47:16];
            seg_len_q    <= seg_of(s_axis_tx_req_data_i[47:16]);
            retry_cnt_q  <= '0;
            meta_valid_q <= 1'b1;
            state_q      <= SEG_CMD;
          end
        end
        SEG_CMD: begin
          if (m_axis_tx_metadata_ready_i) begin
            meta_valid_q <= 1'b0;
            stat_ready_q <= 1'b1;
            state_q      <= WAIT_STATUS;
          end
        end
        WAIT_STATUS: begin
          if (stat_hs) begin
            stat_ready_q <= 1'b0;
            if (err == 2'd0) begin
              retry_cnt_q <= '0;
              beat_cnt_q  <= '0;
              state_q     <= SEG_DATA;
            end else if (fatal) begin
              drops_q <= drops_q + 32'd1;
              state_q <= DROP;
            end else begin
              retry_cnt_q <= retry_cnt_q + 32'd1;
              retries_q   <= retries_q + 32'd1;
              backoff_q   <= '0;
              state_q     <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          if (backoff_q + 32'd1 >= 32'(RETRY_WAIT)) begin
            meta_valid_q <= 1'b1;
            state_q      <= SEG_CMD;
          end else begin
            backoff_q <= backoff_q + 32'd1;
          end
        end
        SEG_DATA: begin
          if (down_hs) begin
            if (last_beat) begin
              seg_cnt_q   <= seg_cnt_q + 32'd1;
              remaining_q <= rem_after;
              beat_cnt_q  <= '0;
              if (rem_after == 32'd0) begin
                state_q <= IDLE;
              end else begin
                seg_len_q    <= seg_of(rem_after);
                meta_valid_q <= 1'b1;
                state_q      <= SEG_CMD;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 11'd1;
            end
          end
        end
        DROP: begin
          if (s_axis_tx_data_valid_i && s_axis_tx_data_last_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TX_SEGMENTER_LATENCY_EN
  logic [31:0] lat_q;
  logic        lat_run_q;

  // Runs from request accept; freezes at the final beat or at the drop decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q     <= '0;
      lat_run_q <= 1'b0;
    end else if ((state_q == IDLE) && req_ready_q && s_axis_tx_req_valid_i) begin
      lat_q     <= '0;
      lat_run_q <= 1'b1;
    end else if (lat_run_q) begin
      if (stat_hs && (err != 2'd0) && fatal) begin
        lat_run_q <= 1'b0;
      end else begin
        lat_q <= lat_q + 32'd1;
        if (down_hs && last_beat && final_seg) lat_run_q <= 1'b0;
      end
    end
  end

  assign latency_cycles_o = lat_q;
`endif

endmodule

// File: tb/tb_tcp_tx_segmenter.sv
// Randomized self-checking bench for tcp_tx_segmenter against a segment-level reference model.
module tb_tcp_tx_segmenter;
  localparam int MSB = 1024;
  localparam int MR  = 8;
  localparam int RW  = 64;
  localparam int LIM = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req_valid, req_ready;
  logic [47:0]  req_data;
  logic         s_valid, s_ready, s_last;
  logic [511:0] s_data;
  logic [63:0]  s_keep;
  logic         meta_valid, meta_ready;
  logic [47:0]  meta_data;
  logic         m_valid, m_ready, m_last;
  logic [511:0] m_data;
  logic [63:0]  m_keep;
  logic         st_valid, st_ready;
  logic [63:0]  st_data;
  logic [127:0] status_reg;

  tcp_tx_segmenter #(.MAX_SEG_BYTES(MSB), .MAX_RETRY(MR), .RETRY_WAIT(RW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tx_req_valid_i(req_valid), .s_axis_tx_req_ready_o(req_ready), .s_axis_tx_req_data_i(req_data),
    .s_axis_tx_data_valid_i(s_valid), .s_axis_tx_data_ready_o(s_ready), .s_axis_tx_data_data_i(s_data),
    .s_axis_tx_data_keep_i(s_keep), .s_axis_tx_data_last_i(s_last),
    .m_axis_tx_metadata_valid_o(meta_valid), .m_axis_tx_metadata_ready_i(meta_ready),
    .m_axis_tx_metadata_data_o(meta_data),
    .m_axis_tx_data_valid_o(m_valid), .m_axis_tx_data_ready_i(m_ready), .m_axis_tx_data_data_o(m_data),
    .m_axis_tx_data_keep_o(m_keep), .m_axis_tx_data_last_o(m_last),
    .s_axis_tx_status_valid_i(st_valid), .s_axis_tx_status_ready_o(st_ready), .s_axis_tx_status_data_i(st_data),
    .status_reg_o(status_reg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles", tag, LIM);
  endtask

  // Reference model state
  int          plan[$];
  int          script[$];
  int          exp_meta[$];
  bit          exp_after_retry[$];
  logic [63:0] exp_keep[$];
  bit          exp_last[$];
  int          exp_segs, exp_retries, exp_drops;
  int          rid = 0;
  bit          abort = 0;
  longint      cyc = 0;

  logic [47:0]  obs_meta[$];
  longint       obs_meta_cyc[$];
  logic [63:0]  obs_keep[$];
  bit           obs_last[$];
  logic [511:0] obs_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (meta_valid && meta_ready) begin
        obs_meta.push_back(meta_data);
        obs_meta_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        obs_keep.push_back(m_keep);
        obs_last.push_back(m_last);
        obs_data.push_back(m_data);
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    meta_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready    = ($urandom_range(0, 3) != 0);
      meta_ready = ($urandom_range(0, 2) != 0);
    end
  end

  function automatic logic [511:0] pat(input int r, input int b);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(r * 65536 + b * 16 + i);
    return d;
  endfunction

  function automatic int rand_err();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 75) return 0;
    if (r < 93) return 1;
    if (r < 97) return 2;
    return 3;
  endfunction

  // Walks the request segment by segment, choosing each status and recording what must come out
  task automatic model(input int len);
    int rem, seg, rt, e, n;
    bit dropped, prev_retry;
    logic [63:0] k;
    rem = len; rt = 0; dropped = 0; prev_retry = 0;
    script.delete(); exp_meta.delete(); exp_after_retry.delete(); exp_keep.delete(); exp_last.delete();
    while (rem > 0 && !dropped) begin
      seg = (rem > MSB) ? MSB : rem;
      exp_meta.push_back(seg);
      exp_after_retry.push_back(prev_retry);
      e = (plan.size() > 0) ? plan.pop_front() : rand_err();
      script.push_back(e);
      if (e == 0) begin
        rt = 0; prev_retry = 0;
        n = (seg + 63) / 64;
        for (int b = 0; b < n; b++) begin
          k = '1;
          if (b == n - 1 && rem <= MSB && (rem % 64) != 0) k = (64'd1 << (rem % 64)) - 64'd1;
          exp_keep.push_back(k);
          exp_last.push_back(b == n - 1);
        end
        rem -= seg;
        exp_segs++;
      end else if (e == 1 && rt < MR) begin
        rt++; exp_retries++; prev_retry = 1;
      end else begin
        dropped = 1; exp_drops++;
      end
    end
    plan.delete();
  endtask

  task automatic drive_req(input int len, input logic [15:0] sess);
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data  = {32'(len), sess};
    t = 0;
    @(negedge clk);
    while (!req_ready && !abort && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) timeout_fail("req_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drive_up(input int nb, input int r);
    int t;
    for (int b = 0; b < nb && !abort; b++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = pat(r, b);
      s_last  = (b == nb - 1);
      t = 0;
      @(negedge clk);
      while (!s_ready && !abort && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) begin timeout_fail("up_beat"); break; end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic drive_status();
    int t;
    for (int i = 0; i < script.size() && !abort; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      st_valid = 1'b1;
      st_data  = {2'(script[i]), 30'($urandom), 16'($urandom), 16'($urandom)};
      t = 0;
      @(negedge clk);
      while (!st_ready && !abort && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) begin timeout_fail("status_accept"); break; end
      @(posedge clk); #1;
      st_valid = 1'b0;
    end
    st_valid = 1'b0;
  endtask

  task automatic prep(input int len);
    obs_meta.delete(); obs_meta_cyc.delete(); obs_keep.delete(); obs_last.delete(); obs_data.delete();
    rid++;
    model(len);
  endtask

  task automatic drive(input int len, input logic [15:0] sess);
    int nb;
    nb = (len + 63) / 64;
    fork
      drive_req(len, sess);
      drive_up(nb, rid);
      drive_status();
    join
  endtask

  task automatic compare(input logic [15:0] sess);
    int t, nm, nbt;
    t = 0;
    while (status_reg[96] && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) timeout_fail("busy_clear");
    check_eq("meta_count", 64'(obs_meta.size()), 64'(exp_meta.size()));
    nm = (obs_meta.size() < exp_meta.size()) ? obs_meta.size() : exp_meta.size();
    for (int i = 0; i < nm; i++) begin
      check_eq("meta_word", 64'(obs_meta[i]), {16'd0, 16'd0, 16'(exp_meta[i]), sess});
      if (i > 0 && exp_after_retry[i])
        check_eq("backoff_gap_ok", 64'((obs_meta_cyc[i] - obs_meta_cyc[i-1]) > RW), 64'd1);
    end
    check_eq("beat_count", 64'(obs_keep.size()), 64'(exp_keep.size()));
    nbt = (obs_keep.size() < exp_keep.size()) ? obs_keep.size() : exp_keep.size();
    for (int i = 0; i < nbt; i++) begin
      check_eq("keep", obs_keep[i], exp_keep[i]);
      check_eq("last", 64'(obs_last[i]), 64'(exp_last[i]));
      check_eq("data_lo", obs_data[i][63:0], pat(rid, i) >> 0);
      check_eq("data_hi", obs_data[i][511:448], 64'(pat(rid, i) >> 448));
    end
    check_eq("segments", 64'(status_reg[31:0]), 64'(exp_segs));
    check_eq("retries", 64'(status_reg[63:32]), 64'(exp_retries));
    check_eq("drops", 64'(status_reg[95:64]), 64'(exp_drops));
    check_eq("busy", 64'(status_reg[127:96]), 64'd0);
  endtask

  task automatic run_req(input int len, input logic [15:0] sess);
    prep(len);
    drive(len, sess);
    compare(sess);
  endtask

  int lens[8] = '{1, 63, 64, 65, 1023, 1024, 1025, 2047};
  int t0;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_data = '0;
    s_valid = 1'b0; s_data = '0; s_keep = '1; s_last = 1'b0;
    st_valid = 1'b0; st_data = '0;
    exp_segs = 0; exp_retries = 0; exp_drops = 0;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_st_ready", 64'(st_ready), 64'd0);
    check_eq("rst_meta_valid", 64'(meta_valid), 64'd0);
    check_eq("rst_status_reg", 64'(status_reg[95:0]), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 64'(status_reg[127:96]), 64'd0);

    plan = '{0, 0, 0};
    run_req(2560, 16'd5);
    plan = '{0};
    run_req(100, 16'd9);
    plan = '{1, 1, 0};
    run_req(1024, 16'd11);
    plan = '{0, 2};
    run_req(2048, 16'd12);
    plan = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_req(1024, 16'd13);
    plan = '{3};
    run_req(700, 16'd14);

    foreach (lens[i]) run_req(lens[i], 16'($urandom));
    for (int i = 0; i < 12; i++) run_req(int'($urandom_range(1, 4000)), 16'($urandom));

    // Reset in the middle of a segment's data, then a fresh short request
    prep(2048);
    plan.delete();
    fork
      drive(2048, 16'd21);
      begin
        t0 = 0;
        while (obs_data.size() < 5 && t0 < LIM) begin @(negedge clk); t0++; end
        if (t0 >= LIM) timeout_fail("mid_data_wait");
        #2;
        abort = 1'b1;
        rst   = 1'b1;
        #1;
        check_eq("abort_m_valid", 64'(m_valid), 64'd0);
        check_eq("abort_meta_valid", 64'(meta_valid), 64'd0);
        check_eq("abort_st_ready", 64'(st_ready), 64'd0);
        check_eq("abort_req_ready", 64'(req_ready), 64'd0);
        check_eq("abort_counters", 64'(status_reg[95:0]), 64'd0);
        check_eq("abort_busy", 64'(status_reg[127:96]), 64'd0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 1'b0;
    exp_segs = 0; exp_retries = 0; exp_drops = 0;
    plan = '{0};
    run_req(64, 16'd22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
